// File: rtl/rv32i_inst_encoder_pkg.sv
// ============================================================================
// Module      : rv32i_inst_encoder_pkg
// Description : Format codes, legal funct7 values and immediate range helper
//               shared by the RV32I instruction encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_inst_encoder_pkg;

    localparam int INST_WIDTH = 32;
    localparam int FMT_WIDTH  = 3;

    localparam logic [FMT_WIDTH-1:0] c_FMT_R = 3'd0;
    localparam logic [FMT_WIDTH-1:0] c_FMT_I = 3'd1;
    localparam logic [FMT_WIDTH-1:0] c_FMT_S = 3'd2;
    localparam logic [FMT_WIDTH-1:0] c_FMT_B = 3'd3;
    localparam logic [FMT_WIDTH-1:0] c_FMT_U = 3'd4;
    localparam logic [FMT_WIDTH-1:0] c_FMT_J = 3'd5;

    localparam logic [6:0] c_F7_BASE   = 7'b0000000;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;
    localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

    // True when value survives truncation to a signed field of the given width.
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned bits);
        logic [31:0] w_hi;
        w_hi = $signed(value) >>> (bits - 1);
        return (w_hi == '0) || (w_hi == '1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_inst_encoder_fifo.sv
// ============================================================================
// Module      : rv32_enc_fifo
// Description : Synchronous FIFO with async reset, explicit occupancy count
//               and a combinational head read from registered storage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_enc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [PTR_W:0]   c_CNT_ONE = 1;
    localparam logic [PTR_W:0]   c_DEPTH   = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_DEPTH);
    assign o_empty   = (r_count == '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/rv32i_inst_encoder.sv
// ============================================================================
// Module      : rv32i_inst_encoder
// Description : Assembles RV32I instruction words from decoded fields, flags
//               out-of-range immediates, and queues results in an output FIFO.
//               Define RV32M_EN to accept funct7=0000001 (MUL/DIV) in R format.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_inst_encoder
    import rv32i_inst_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FMT_WIDTH-1:0]  in_fmt,
    input  logic [6:0]            in_opcode,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [31:0]           in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic                  out_err,
    output logic [CNT_WIDTH-1:0]  inst_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = 1;

    logic [INST_WIDTH-1:0] w_raw;
    logic                  w_bad;
    logic [INST_WIDTH-1:0] w_word;
    logic                  w_f7_ok;
    logic                  w_fire;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [INST_WIDTH:0]   w_head;

    logic                  r_e_full;
    logic [INST_WIDTH-1:0] r_e_inst;
    logic                  r_e_err;
    logic [CNT_WIDTH-1:0]  r_inst_count;
    logic [CNT_WIDTH-1:0]  r_err_count;

`ifdef RV32M_EN
    assign w_f7_ok = (in_funct7 == c_F7_BASE) || (in_funct7 == c_F7_ALT) ||
                     (in_funct7 == c_F7_MULDIV);
`else
    assign w_f7_ok = (in_funct7 == c_F7_BASE) || (in_funct7 == c_F7_ALT);
`endif

    always_comb begin
        w_raw = '0;
        w_bad = 1'b0;
        case (in_fmt)
            c_FMT_R: begin
                w_raw = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                w_bad = ~w_f7_ok;
            end
            c_FMT_I: begin
                w_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                w_bad = ~fits_signed(in_imm, 12);
            end
            c_FMT_S: begin
                w_raw = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                w_bad = ~fits_signed(in_imm, 12);
            end
            c_FMT_B: begin
                w_raw = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
                w_bad = ~fits_signed(in_imm, 13) | in_imm[0];
            end
            c_FMT_U: begin
                w_raw = {in_imm[31:12], in_rd, in_opcode};
                w_bad = (in_imm[11:0] != 12'h000);
            end
            c_FMT_J: begin
                w_raw = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                w_bad = ~fits_signed(in_imm, 21) | in_imm[0];
            end
            default: begin
                w_bad = 1'b1;
            end
        endcase
    end

    // Rejected requests become the all-zero word, which decodes as illegal.
    assign w_word    = w_bad ? '0 : w_raw;

    assign in_ready  = ~r_e_full | ~w_full;
    assign w_fire    = in_valid & in_ready;
    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign w_push    = r_e_full & (~w_full | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e_full <= 1'b0;
            r_e_inst <= '0;
            r_e_err  <= 1'b0;
        end else if (w_fire) begin
            r_e_full <= 1'b1;
            r_e_inst <= w_word;
            r_e_err  <= w_bad;
        end else if (w_push) begin
            r_e_full <= 1'b0;
        end
    end

    rv32_enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INST_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  ({r_e_err, r_e_inst}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_err  = w_head[INST_WIDTH];
    assign out_inst = w_head[INST_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst_count <= '0;
            r_err_count  <= '0;
        end else begin
            if (w_pop) begin
                r_inst_count <= r_inst_count + c_CNT_ONE;
            end
            if (w_push && r_e_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + c_CNT_ONE;
            end
        end
    end

    assign inst_count = r_inst_count;
    assign err_count  = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_inst_encoder.sv
// ============================================================================
// Module      : tb_rv32i_inst_encoder
// Description : Self-checking bench: directed vectors plus randomized traffic
//               checked against an arithmetic model of the encoding rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32i_inst_encoder;

    localparam int FIFO_DEPTH = 2;
    localparam int CNT_WIDTH  = 16;
`ifdef RV32M_EN
    localparam bit c_M_EN = 1'b1;
`else
    localparam bit c_M_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic        out_err;
    logic [CNT_WIDTH-1:0] inst_count;
    logic [CNT_WIDTH-1:0] err_count;

    always #5 clk = ~clk;

    rv32i_inst_encoder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_err    (out_err),
        .inst_count (inst_count),
        .err_count  (err_count)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [32:0] exp_q[$];
    int          m_pops = 0;
    int          m_errs = 0;
    logic [32:0] mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {err, word} from field arithmetic and integer range tests.
    function automatic logic [32:0] model(input logic [2:0] fmt, input logic [6:0] op,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] w;
        bit          ok;
        int          v;
        v  = $signed(imm);
        ok = 1'b1;
        w  = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20);
        case (fmt)
            3'd0: begin
                ok = (f7 == 7'd0) || (f7 == 7'd32) || (c_M_EN && f7 == 7'd1);
                w  = w | (32'(f7) << 25);
            end
            3'd1: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) |
                     ((imm & 32'hFFF) << 20);
            end
            3'd2: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = 32'(op) | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) |
                     (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
            end
            3'd3: begin
                ok = (v >= -4096) && (v <= 4095) && (v % 2 == 0);
                w  = 32'(op) | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8) |
                     (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20) |
                     (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
            end
            3'd4: begin
                ok = (imm % 4096) == 0;
                w  = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
            end
            3'd5: begin
                ok = (v >= -1048576) && (v <= 1048575) && (v % 2 == 0);
                w  = 32'(op) | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12) |
                     (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21) |
                     (((imm >> 20) & 32'h1) << 31);
            end
            default: ok = 1'b0;
        endcase
        return ok ? {1'b0, w} : {1'b1, 32'h0};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            check("inst_count", 64'(inst_count), 64'(CNT_WIDTH'(m_pops)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL pop_order: got 0x%0h, required no entry", {out_err, out_inst});
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_word", 64'({out_err, out_inst}), 64'(mon_e));
                end
                m_pops++;
            end
            if (in_valid && in_ready) begin
                mon_e = model(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
                exp_q.push_back(mon_e);
                if (mon_e[32]) m_errs++;
            end
        end
    end

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    endtask

    task automatic wait_fire();
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL fire_timeout: got in_ready=0, required 1");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [2:0] f, input logic [6:0] op,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                            input logic [32:0] exp);
        drive(f, op, rd, rs1, rs2, f3, f7, imm);
        wait_fire();
        @(negedge clk);
        check({name, "_valid_early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_word"}, 64'({out_err, out_inst}), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d entries left, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        exp_q.delete();
        m_pops = 0;
        m_errs = 0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int bnd[14] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                    1048574, 1048576, -1048576, -1048578, 32'h12345000, 0};

    initial begin
        int          acc;
        int          t;
        bit          took;
        logic [32:0] r_exp;

        check("model_R",  64'(model(0, 7'b0110011, 0, 1, 2, 0, 0, 0)), 64'h0_00208033);
        check("model_I",  64'(model(1, 7'b0010011, 1, 0, 0, 0, 0, 5)), 64'h0_00500093);
        check("model_S",  64'(model(2, 7'b0100011, 0, 1, 2, 2, 0, 8)), 64'h0_0020A423);
        check("model_J",  64'(model(5, 7'b1101111, 1, 0, 0, 0, 0, 2048)), 64'h0_001000EF);
        check("model_B8", 64'(model(3, 7'b1100011, 0, 1, 2, 0, 0, -8)), 64'h0_FE208CE3);

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        #2 reset = 1'b0;
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        r_exp = c_M_EN ? 33'h0_02208033 : 33'h1_00000000;
        directed("R_add", 0, 7'b0110011, 0, 1, 2, 0, 7'd0, 0, 33'h0_00208033);
        directed("R_mul", 0, 7'b0110011, 0, 1, 2, 0, 7'd1, 0, r_exp);
        check("err_count_R", 64'(err_count), c_M_EN ? 64'd0 : 64'd1);
        directed("I_addi", 1, 7'b0010011, 1, 0, 0, 0, 0, 5, 33'h0_00500093);
        directed("S_sw", 2, 7'b0100011, 0, 1, 2, 3'b010, 0, 8, 33'h0_0020A423);
        directed("J_jal", 5, 7'b1101111, 1, 0, 0, 0, 0, 2048, 33'h0_001000EF);
        directed("U_lui", 4, 7'b0110111, 5, 0, 0, 0, 0, 32'h12345000, 33'h0_123452B7);
        directed("B_odd", 3, 7'b1100011, 0, 1, 2, 0, 0, 3, 33'h1_00000000);
        check("err_count_dir", 64'(err_count), c_M_EN ? 64'd1 : 64'd2);

        // Backpressure: with the consumer stalled only FIFO_DEPTH+1 requests fit.
        do_reset();
        out_ready = 1'b0;
        acc = 0;
        drive(1, 7'b0010011, 5'd0, 5'd3, 0, 0, 0, 32'd1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                acc++;
                if (acc < 4) drive(1, 7'b0010011, 5'(acc), 5'd3, 0, 0, 0, 32'(acc + 1));
                else in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("bp_accepts", 64'(acc), 64'(FIFO_DEPTH + 1));
        check("bp_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        t = 0;
        while (acc < 4 && t < 20) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                acc++;
                in_valid = 1'b0;
            end
            t++;
        end
        wait_drain();
        check("bp_inst_count", 64'(inst_count), 64'd4);

        // Reset while the FIFO holds two entries.
        out_ready = 1'b0;
        @(posedge clk);
        #1 drive(3, 7'b1100011, 0, 1, 2, 0, 0, 32'd3);
        wait_fire();
        drive(1, 7'b0010011, 2, 0, 0, 0, 0, 32'd7);
        wait_fire();
        repeat (3) @(negedge clk);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_err_count", 64'(err_count), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_inst_count", 64'(inst_count), 64'd0);
        check("async_rst_err_count", 64'(err_count), 64'd0);
        check("async_rst_out_inst", 64'(out_inst), 64'd0);
        exp_q.delete();
        m_pops = 0;
        m_errs = 0;
        @(negedge clk);
        #2 reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        directed("post_rst_I", 1, 7'b0010011, 1, 0, 0, 0, 0, 5, 33'h0_00500093);
        wait_drain();
        check("post_rst_err_count", 64'(err_count), 64'd0);

        // Randomized traffic against the model.
        do_reset();
        took = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            if (took || !in_valid) begin
                if ($urandom % 4 != 0) begin
                    in_valid  = 1'b1;
                    in_fmt    = 3'($urandom % 8);
                    in_opcode = 7'($urandom);
                    in_rd     = 5'($urandom);
                    in_rs1    = 5'($urandom);
                    in_rs2    = 5'($urandom);
                    in_funct3 = 3'($urandom);
                    case ($urandom % 4)
                        0: in_funct7 = 7'd0;
                        1: in_funct7 = 7'd32;
                        2: in_funct7 = 7'd1;
                        default: in_funct7 = 7'($urandom);
                    endcase
                    case ($urandom % 5)
                        0: in_imm = 32'($urandom_range(0, 63)) - 32'd32;
                        1: in_imm = $urandom;
                        2: in_imm = bnd[$urandom % 14];
                        3: in_imm = $urandom & 32'hFFFF_F000;
                        default: in_imm = ($urandom & 32'h0000_1FFE) - 32'h1000;
                    endcase
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom % 4) != 0;
            @(negedge clk);
            took = in_valid && in_ready;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("rand_err_count", 64'(err_count), 64'(CNT_WIDTH'(m_errs)));
        check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
